ob_mk_table_accum: RTL and testbench

Parametrised order-book table accumulator. It sums the `quantity` field of valid table entries in rounds of `LANES` entries per cycle, starting from the highest-priority entry (index 0). It can stop early once a caller-supplied goal is reached or the valid region of the table ends. It sits beside the match engine, which uses it to size market orders against resting depth, and it reports both the accumulated quantity and the number of entries consumed.

---
 rtl/ob_mk_table_accum.sv | 164 ++++++++++++++++
 tb/tb_ob_mk_table_accum.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ob_mk_table_accum.sv
// ob_pkg: shared order-book types.
// ob_mk_table_accum: sums the quantity of valid table entries, LANES entries
// per cycle starting at index 0, with optional early stop once a goal is met.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_vld/cmd_rdy   command handshake (accepted only in IDLE)
//   cmd_mode          0 = sum all valid entries, 1 = stop once goal reached
//   cmd_goal          goal threshold, latched on accept
//   tbl_r, tbl_vld_r  table contents and valid flags (held stable while busy)
//   rsp_vld           one-cycle response strobe
//   rsp_quantity      accumulated quantity
//   rsp_entries       number of valid entries included in the sum
//   rsp_goal_met      rsp_quantity >= latched goal
//   busy              a command is in flight

package ob_pkg;
    typedef logic [15:0] quantity_t;
    typedef logic [23:0] accum_quantity_t;
    typedef logic [15:0] price_t;

    typedef struct packed {
        price_t    price;
        quantity_t quantity;
    } table_t;
endpackage

// state | meaning
// ------+------------------------------------------------
// IDLE  | waiting for a command, cmd_rdy high
// ACCUM | one round of LANES entries per cycle
// RESP  | rsp_vld high for one cycle, then back to IDLE
module ob_mk_table_accum #(
    parameter int N     = 16,
    parameter int LANES = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_vld,
    output logic                        cmd_rdy,
    input  logic                        cmd_mode,
    input  ob_pkg::accum_quantity_t     cmd_goal,
    input  ob_pkg::table_t [N-1:0]      tbl_r,
    input  logic [N-1:0]                tbl_vld_r,
    output logic                        rsp_vld,
    output ob_pkg::accum_quantity_t     rsp_quantity,
    output logic [$clog2(N+1)-1:0]      rsp_entries,
    output logic                        rsp_goal_met,
    output logic                        busy
);
    import ob_pkg::*;

    localparam int ROUNDS = (N + LANES - 1) / LANES;
    localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int CW     = $clog2(N + 1);
    localparam int IW     = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    if ($bits(accum_quantity_t) < $bits(quantity_t) + $clog2(N)) begin : g_acc_width_chk
        $fatal(1, "accum_quantity_t too narrow for N entries");
    end
    if (LANES < 1) begin : g_lanes_chk
        $fatal(1, "LANES must be at least 1");
    end

    logic [1:0]        state;
    logic [RW-1:0]     round;
    accum_quantity_t   acc;
    logic [CW-1:0]     cnt;
    logic              mode_q;
    accum_quantity_t   goal_q;

    accum_quantity_t   lane_sum;
    logic [CW-1:0]     lane_cnt;
    logic              lane_gap;
    accum_quantity_t   acc_next;
    logic [CW-1:0]     cnt_next;
    logic              last_round;
    logic              unused_price;

    // Combinational reduction of the current round. A lane beyond N adds
    // nothing; an in-range invalid lane marks the end of the compacted region.
    always_comb begin
        int idx;
        lane_sum     = '0;
        lane_cnt     = '0;
        lane_gap     = 1'b0;
        unused_price = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            idx = int'(round) * LANES + i;
            if (idx < N) begin
                if (tbl_vld_r[IW'(idx)]) begin
                    lane_sum = lane_sum + accum_quantity_t'(tbl_r[IW'(idx)].quantity);
                    lane_cnt = lane_cnt + CW'(1);
                end else begin
                    lane_gap = 1'b1;
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            unused_price = unused_price ^ (^tbl_r[j].price);
        end
    end

    assign acc_next   = acc + lane_sum;
    assign cnt_next   = cnt + lane_cnt;
    assign last_round = (round == RW'(ROUNDS - 1)) || lane_gap ||
                        (mode_q && (acc_next >= goal_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            round        <= '0;
            acc          <= '0;
            cnt          <= '0;
            mode_q       <= 1'b0;
            goal_q       <= '0;
            rsp_quantity <= '0;
            rsp_entries  <= '0;
            rsp_goal_met <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_vld) begin
                        state        <= ACCUM;
                        mode_q       <= cmd_mode;
                        goal_q       <= cmd_goal;
                        round        <= '0;
                        acc          <= '0;
                        cnt          <= '0;
                        rsp_quantity <= '0;
                        rsp_entries  <= '0;
                        rsp_goal_met <= 1'b0;
                    end
                end
                ACCUM: begin
                    acc   <= acc_next;
                    cnt   <= cnt_next;
                    round <= round + RW'(1);
                    if (last_round) begin
                        state        <= RESP;
                        rsp_quantity <= acc_next;
                        rsp_entries  <= cnt_next;
                        rsp_goal_met <= (acc_next >= goal_q);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_rdy = (state == IDLE);
    assign busy    = (state != IDLE);
    assign rsp_vld = (state == RESP);

endmodule

// File: tb/tb_ob_mk_table_accum.sv
module tb_ob_mk_table_accum;
    import ob_pkg::*;

    logic                    clk;
    logic                    rst;
    logic                    cmd_vld;
    logic                    cmd_rdy;
    logic                    cmd_mode;
    accum_quantity_t         cmd_goal;
    table_t [15:0]           tbl;
    logic [15:0]             tbl_vld;
    logic                    rsp_vld;
    accum_quantity_t         rsp_quantity;
    logic [4:0]              rsp_entries;
    logic                    rsp_goal_met;
    logic                    busy;

    logic                    cmd_vld2;
    logic                    cmd_rdy2;
    table_t [3:0]            tbl2;
    logic [3:0]              tbl_vld2;
    logic                    rsp_vld2;
    accum_quantity_t         rsp_quantity2;
    logic [2:0]              rsp_entries2;
    logic                    rsp_goal_met2;
    logic                    busy2;

    int checks = 0;
    int errors = 0;

    ob_mk_table_accum #(.N(16), .LANES(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_mode(cmd_mode), .cmd_goal(cmd_goal),
        .tbl_r(tbl), .tbl_vld_r(tbl_vld),
        .rsp_vld(rsp_vld), .rsp_quantity(rsp_quantity), .rsp_entries(rsp_entries),
        .rsp_goal_met(rsp_goal_met), .busy(busy)
    );

    ob_mk_table_accum #(.N(4), .LANES(6)) dut4 (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld2), .cmd_rdy(cmd_rdy2), .cmd_mode(1'b0), .cmd_goal(24'd0),
        .tbl_r(tbl2), .tbl_vld_r(tbl_vld2),
        .rsp_vld(rsp_vld2), .rsp_quantity(rsp_quantity2), .rsp_entries(rsp_entries2),
        .rsp_goal_met(rsp_goal_met2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_tbl(input int mode_fill, input int nvalid);
        for (int i = 0; i < 16; i++) begin
            tbl[i].price    = 16'(100 + i);
            tbl[i].quantity = (mode_fill == 0) ? 16'(i + 1) : 16'(mode_fill);
            tbl_vld[i]      = (i < nvalid);
        end
    endtask

    // Issue one command from IDLE and track the response cycle by cycle.
    task automatic run_cmd(input string tag, input logic mode, input int goal,
                           input int exp_q, input int exp_e, input logic exp_gm,
                           input int rounds);
        int lat, nv;
        logic rdy_after;
        accum_quantity_t q;
        logic [4:0] e;
        logic gm;
        lat = 0; nv = 0; rdy_after = 1'b0; q = '0; e = '0; gm = 1'b0;
        cmd_mode = mode;
        cmd_goal = 24'(goal);
        cmd_vld  = 1'b1;
        chk({tag, "_rdy_pre"}, 32'(cmd_rdy), 1);
        next_cyc();
        cmd_vld = 1'b0;
        chk({tag, "_busy_t1"}, 32'(busy), 1);
        chk({tag, "_rsp_clr"}, 32'(rsp_quantity), 0);
        for (int c = 1; c <= 8; c++) begin
            if (rsp_vld) begin
                nv++;
                if (lat == 0) begin
                    lat = c; q = rsp_quantity; e = rsp_entries; gm = rsp_goal_met;
                end
            end
            if (lat != 0 && c == lat + 1) rdy_after = cmd_rdy;
            if (c < 8) next_cyc();
        end
        chk({tag, "_latency"}, 32'(lat), 32'(rounds + 1));
        chk({tag, "_vld_once"}, 32'(nv), 1);
        chk({tag, "_qty"}, 32'(q), 32'(exp_q));
        chk({tag, "_entries"}, 32'(e), 32'(exp_e));
        chk({tag, "_goal_met"}, 32'(gm), 32'(exp_gm));
        chk({tag, "_rdy_after"}, 32'(rdy_after), 1);
        chk({tag, "_qty_hold"}, 32'(rsp_quantity), 32'(exp_q));
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin : main
        logic [6:0] rdy_bits;
        logic [6:0] rsp_bits;
        logic [6:0] gm_bits;
        int nv;

        rst = 1'b1; cmd_vld = 1'b0; cmd_mode = 1'b0; cmd_goal = '0;
        cmd_vld2 = 1'b0;
        fill_tbl(0, 16);
        for (int i = 0; i < 4; i++) begin
            tbl2[i].price = 16'(i); tbl2[i].quantity = 16'd5; tbl_vld2[i] = 1'b1;
        end
        #3;
        chk("rst_rdy", 32'(cmd_rdy), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_vld", 32'(rsp_vld), 0);
        chk("rst_qty", 32'(rsp_quantity), 0);
        chk("rst_entries", 32'(rsp_entries), 0);
        chk("rst_goal_met", 32'(rsp_goal_met), 0);
        next_cyc();
        rst = 1'b0;
        next_cyc();

        fill_tbl(0, 16);
        run_cmd("sum_all_ramp", 1'b0, 200, 136, 16, 1'b0, 3);

        fill_tbl(10, 4);
        run_cmd("sum_partial4", 1'b0, 0, 40, 4, 1'b1, 1);

        fill_tbl(10, 6);
        run_cmd("sum_partial6", 1'b0, 100, 60, 6, 1'b0, 2);

        fill_tbl(10, 16);
        run_cmd("goal50", 1'b1, 50, 60, 6, 1'b1, 1);
        run_cmd("goal1000", 1'b1, 1000, 160, 16, 1'b0, 3);
        run_cmd("goal120", 1'b1, 120, 120, 12, 1'b1, 2);

        // Reset in the middle of round 1.
        cmd_mode = 1'b0; cmd_goal = '0; cmd_vld = 1'b1;
        next_cyc();
        cmd_vld = 1'b0;
        next_cyc();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rdy", 32'(cmd_rdy), 1);
        chk("mid_rst_rsp_vld", 32'(rsp_vld), 0);
        chk("mid_rst_qty", 32'(rsp_quantity), 0);
        chk("mid_rst_entries", 32'(rsp_entries), 0);
        next_cyc();
        rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_vld) nv++;
            next_cyc();
        end
        chk("mid_rst_no_rsp", 32'(nv), 0);
        fill_tbl(1, 16);
        run_cmd("after_rst", 1'b0, 0, 16, 16, 1'b1, 3);

        // Back-to-back UNTIL_GOAL with goal 0 and cmd_vld held high.
        fill_tbl(10, 16);
        cmd_mode = 1'b1; cmd_goal = '0; cmd_vld = 1'b1;
        for (int c = 0; c < 7; c++) begin
            rdy_bits[c] = cmd_rdy;
            rsp_bits[c] = rsp_vld;
            gm_bits[c]  = rsp_goal_met & rsp_vld;
            next_cyc();
        end
        cmd_vld = 1'b0;
        chk("b2b_accepts", 32'(rdy_bits), 32'(7'b1001001));
        chk("b2b_rsp", 32'(rsp_bits), 32'(7'b0100100));
        chk("b2b_goal_met", 32'(gm_bits), 32'(7'b0100100));
        for (int c = 0; c < 4; c++) next_cyc();
        chk("b2b_idle", 32'(busy), 0);

        // N=4, LANES=6: single round.
        cmd_vld2 = 1'b1;
        next_cyc();
        cmd_vld2 = 1'b0;
        chk("n4_busy", 32'(busy2), 1);
        next_cyc();
        chk("n4_rsp_vld", 32'(rsp_vld2), 1);
        chk("n4_qty", 32'(rsp_quantity2), 20);
        chk("n4_entries", 32'(rsp_entries2), 4);
        next_cyc();
        chk("n4_rdy", 32'(cmd_rdy2), 1);
        chk("n4_rsp_low", 32'(rsp_vld2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
